// File: rtl/rv32_pkg.sv
// Shared encodings for the multi-cycle RV32I core: opcodes, datapath
// select codes and the control-sequencer state enumeration.
package rv32_pkg;

    localparam int unsigned OPC_W = 7;

    // Major opcodes (IR[6:0])
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

    // Immediate generator format select
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // ALU operation
    localparam logic [1:0] ALU_OP_ADD    = 2'd0;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'd1;
    localparam logic [1:0] ALU_OP_PASS_B = 2'd2;

    // ALU operand A source
    localparam logic [1:0] ALU_A_PC     = 2'd0;
    localparam logic [1:0] ALU_A_RS1    = 2'd1;
    localparam logic [1:0] ALU_A_OLD_PC = 2'd2;
    localparam logic [1:0] ALU_A_ZERO   = 2'd3;

    // ALU operand B source
    localparam logic [1:0] ALU_B_RS2  = 2'd0;
    localparam logic [1:0] ALU_B_IMM  = 2'd1;
    localparam logic [1:0] ALU_B_STEP = 2'd2;

    // Register-file write-back source
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    // PC load source
    localparam logic [1:0] PC_SRC_ALU     = 2'd0;
    localparam logic [1:0] PC_SRC_ALU_OUT = 2'd1;
    localparam logic [1:0] PC_SRC_JALR    = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_LUI,
        S_AUIPC,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_TRAP
    } ctl_state_e;

    // Immediate format implied by the opcode (I for anything without its own format)
    function automatic logic [2:0] imm_for_opcode(input logic [OPC_W-1:0] opc);
        logic [2:0] sel;
        sel = IMM_I;
        case (opc)
            OPC_STORE:            sel = IMM_S;
            OPC_BRANCH:           sel = IMM_B;
            OPC_LUI, OPC_AUIPC:   sel = IMM_U;
            OPC_JAL:              sel = IMM_J;
            default:              sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main sequencer of the multi-cycle RV32I core. Steps each instruction through
// fetch/decode/execute/memory/write-back, drives every datapath strobe and
// mux select, counts retired instructions and traps on unknown opcodes.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   opcode                IR[6:0], stable from the cycle after ir_write
//   br_taken              branch comparator result, used in BRANCH
//   mem_ready             memory read data valid / write accepted
//   mem_read, mem_write   memory requests; iord selects address (0 PC, 1 ALU)
//   ir_write, pc_write    IR / PC load enables; pc_src selects PC source
//   imm_sel               immediate format to the immediate generator
//   alu_a, alu_b, alu_op  ALU operand selects and operation
//   reg_write, wb_sel     register-file write enable and data source
//   trap                  one-cycle illegal-opcode pulse
//   instret               retired-instruction count
// Strobes are decoded from the current state (plus mem_ready/br_taken where
// the handshake needs it), so they are combinational by design.
module multicycle_control
    import rv32_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PC_STEP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [2:0]       imm_sel,
    output logic [1:0]       alu_a,
    output logic [1:0]       alu_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    // The step constant itself lives in the datapath; reject a meaningless value here.
    if (PC_STEP == 0) begin : g_bad_pc_step
        $error("multicycle_control: PC_STEP must be nonzero");
    end

    ctl_state_e       state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire_c;

    // State and retire counter; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        retire_c  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_SRC_ALU;
        imm_sel   = IMM_I;
        alu_a     = ALU_A_PC;
        alu_b     = ALU_B_RS2;
        alu_op    = ALU_OP_ADD;
        reg_write = 1'b0;
        wb_sel    = WB_SEL_ALU;
        trap      = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                alu_a    = ALU_A_PC;
                alu_b    = ALU_B_STEP;
                alu_op   = ALU_OP_ADD;
                pc_src   = PC_SRC_ALU;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively form old PC + imm so BRANCH/JAL find the target in ALU_OUT.
                alu_a   = ALU_A_OLD_PC;
                alu_b   = ALU_B_IMM;
                alu_op  = ALU_OP_ADD;
                imm_sel = imm_for_opcode(opcode);
                case (opcode)
                    OPC_OP:              state_d = S_EXEC_R;
                    OPC_OP_IMM:          state_d = S_EXEC_I;
                    OPC_LOAD, OPC_STORE: state_d = S_ADDR;
                    OPC_BRANCH:          state_d = S_BRANCH;
                    OPC_JAL:             state_d = S_JAL;
                    OPC_JALR:            state_d = S_JALR;
                    OPC_LUI:             state_d = S_LUI;
                    OPC_AUIPC:           state_d = S_AUIPC;
                    default:             state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_a   = ALU_A_RS1;
                alu_b   = ALU_B_RS2;
                alu_op  = ALU_OP_FUNCT;
                state_d = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_a   = ALU_A_RS1;
                alu_b   = ALU_B_IMM;
                alu_op  = ALU_OP_FUNCT;
                imm_sel = IMM_I;
                state_d = S_WB_ALU;
            end
            S_LUI: begin
                alu_a   = ALU_A_ZERO;
                alu_b   = ALU_B_IMM;
                alu_op  = ALU_OP_ADD;
                imm_sel = IMM_U;
                state_d = S_WB_ALU;
            end
            S_AUIPC: begin
                alu_a   = ALU_A_OLD_PC;
                alu_b   = ALU_B_IMM;
                alu_op  = ALU_OP_ADD;
                imm_sel = IMM_U;
                state_d = S_WB_ALU;
            end
            S_ADDR: begin
                alu_a  = ALU_A_RS1;
                alu_b  = ALU_B_IMM;
                alu_op = ALU_OP_ADD;
                if (opcode == OPC_STORE) begin
                    imm_sel = IMM_S;
                    state_d = S_MEM_WR;
                end else begin
                    imm_sel = IMM_I;
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                wb_sel    = WB_SEL_ALU;
                retire_c  = 1'b1;
                state_d   = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write = 1'b1;
                wb_sel    = WB_SEL_MEM;
                retire_c  = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                imm_sel  = IMM_B;
                pc_src   = PC_SRC_ALU_OUT;
                pc_write = br_taken;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                imm_sel   = IMM_J;
                pc_src    = PC_SRC_ALU_OUT;
                pc_write  = 1'b1;
                reg_write = 1'b1;
                wb_sel    = WB_SEL_LINK;
                retire_c  = 1'b1;
                state_d   = S_FETCH;
            end
            S_JALR: begin
                alu_a     = ALU_A_RS1;
                alu_b     = ALU_B_IMM;
                alu_op    = ALU_OP_ADD;
                imm_sel   = IMM_I;
                pc_src    = PC_SRC_JALR;
                pc_write  = 1'b1;
                reg_write = 1'b1;
                wb_sel    = WB_SEL_LINK;
                retire_c  = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                trap    = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset suppresses every side effect in the cycle it is asserted.
        if (reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            trap      = 1'b0;
            retire_c  = 1'b0;
        end

        // Wraps silently at all-ones.
        instret_d = instret_q + (retire_c ? CNT_W'(1) : CNT_W'(0));
    end

    assign instret = instret_q;

endmodule
